// File: rtl/sha3_wb_ctrl.sv
// Wishbone register front end for a SHA-3 core: input word FIFO, absorb/squeeze sequencing, digest capture.
// Optional feature: define SHA3_CTRL_IRQ_EN to store the IE bit and drive irq[1:0].
`timescale 1ns/1ps
module sha3_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  output logic         core_in_valid,
  input  logic         core_in_ready,
  output logic [31:0]  core_in_data,
  output logic         core_in_last,
  output logic [2:0]   core_in_bytes,
  output logic         core_start,
  output logic         core_abort,
  input  logic         core_out_valid,
  input  logic [255:0] core_out_data,
  output logic [2:0]   irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ABSORB, SQUEEZE} state_t;

  function automatic logic [2:0] sel_to_bytes(input logic [3:0] sel);
    case (sel)
      4'b0001: sel_to_bytes = 3'd1;
      4'b0011: sel_to_bytes = 3'd2;
      4'b0111: sel_to_bytes = 3'd3;
      4'b1111: sel_to_bytes = 3'd4;
      default: sel_to_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] sat_count(input logic [4:0] c);
    sat_count = (c > 5'd7) ? 3'd7 : c[2:0];
  endfunction

  state_t          state_q, state_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic            start_q, start_d;
  logic            abort_q, abort_d;
  logic            err_q, err_d;
  logic            dv_q, dv_d;
  logic [255:0]    digest_q, digest_d;
  logic            last_pushed_q, last_pushed_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [35:0]     fifo_mem [FIFO_DEPTH];
  logic            mem_we;
  logic [35:0]     mem_wdata;
  logic [35:0]     head;

  logic            hit, req, wr, rd;
  logic [3:0]      off;
  logic            full, empty, pop;
  logic            ctrl_wr, data_wr, do_abort, do_start, clr_err;
  logic            push_last, push_ok;
  logic [2:0]      push_bytes;
  logic [4:0]      count_x;
  logic            ie_rd;
  logic [31:0]     rdata;
  logic            unused_bits;

  assign hit     = (wbs_adr_i[31:6] == BASE_ADDR[31:6]);
  assign req     = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
  assign wr      = req & wbs_we_i;
  assign rd      = req & ~wbs_we_i;
  assign off     = wbs_adr_i[5:2];
  assign count_x = 5'(count_q);
  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign head    = fifo_mem[rd_ptr_q];

  assign core_in_valid = (state_q == ABSORB) && !empty;
  assign pop           = core_in_valid & core_in_ready;
  // Payload is forced to zero when not valid so every output is quiet in reset.
  assign core_in_data  = core_in_valid ? head[31:0]  : 32'd0;
  assign core_in_bytes = core_in_valid ? head[34:32] : 3'd0;
  assign core_in_last  = core_in_valid & head[35];

  assign ctrl_wr    = wr && (off == 4'h0);
  assign do_abort   = ctrl_wr && wbs_dat_i[3];
  assign do_start   = ctrl_wr && wbs_dat_i[0] && !wbs_dat_i[3] && (state_q == IDLE);
  assign clr_err    = ctrl_wr && wbs_dat_i[2];
  assign data_wr    = wr && ((off == 4'h2) || (off == 4'h3));
  assign push_last  = (off == 4'h3);
  assign push_bytes = push_last ? sel_to_bytes(wbs_sel_i) : 3'd4;
  // A full FIFO still accepts a word when the core drains one on the same edge.
  assign push_ok    = data_wr && (state_q == ABSORB) && (!full || pop) &&
                      !last_pushed_q && (push_bytes != 3'd0);
  assign mem_we     = push_ok;
  assign mem_wdata  = {push_last, push_bytes, wbs_dat_i};

  always_comb begin
    rdata = 32'd0;
    case (off)
      4'h0: rdata = {27'd0, ie_rd, 4'd0};
      4'h1: rdata = {24'd0, sat_count(count_x), err_q, empty, full, dv_q, state_q != IDLE};
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF:
            rdata = digest_q[{off[2:0], 5'd0} +: 32];
      default: rdata = 32'd0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    ack_d         = req;
    dat_d         = rd ? rdata : 32'd0;
    start_d       = 1'b0;
    abort_d       = 1'b0;
    err_d         = err_q;
    dv_d          = dv_q;
    digest_d      = digest_q;
    last_pushed_d = last_pushed_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q + CW'(push_ok) - CW'(pop);

    case (state_q)
      IDLE: begin
        if (do_start) begin
          state_d       = ABSORB;
          start_d       = 1'b1;
          dv_d          = 1'b0;
          last_pushed_d = 1'b0;
        end
      end
      ABSORB: begin
        if (pop && head[35]) state_d = SQUEEZE;
      end
      SQUEEZE: begin
        if (core_out_valid) begin
          digest_d = core_out_data;
          dv_d     = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push_ok) begin
      wr_ptr_d      = wr_ptr_q + 1'b1;
      last_pushed_d = push_last;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    if (clr_err)               err_d = 1'b0;
    if (data_wr && !push_ok)   err_d = 1'b1;

    // Abort wins over everything else and never touches the digest.
    if (do_abort) begin
      state_d       = IDLE;
      abort_d       = (state_q != IDLE);
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      last_pushed_d = 1'b0;
      digest_d      = digest_q;
      dv_d          = dv_q;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      ack_q         <= 1'b0;
      dat_q         <= 32'd0;
      start_q       <= 1'b0;
      abort_q       <= 1'b0;
      err_q         <= 1'b0;
      dv_q          <= 1'b0;
      digest_q      <= '0;
      last_pushed_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      dat_q         <= dat_d;
      start_q       <= start_d;
      abort_q       <= abort_d;
      err_q         <= err_d;
      dv_q          <= dv_d;
      digest_q      <= digest_d;
      last_pushed_q <= last_pushed_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (mem_we) fifo_mem[wr_ptr_q] <= mem_wdata;
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign core_start = start_q;
  assign core_abort = abort_q;

`ifdef SHA3_CTRL_IRQ_EN
  logic ie_q, ie_d;

  always_comb begin
    ie_d = ie_q;
    if (ctrl_wr) ie_d = wbs_dat_i[4];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) ie_q <= 1'b0;
    else          ie_q <= ie_d;
  end

  assign ie_rd = ie_q;
  assign irq   = {1'b0, err_q & ie_q, dv_q & ie_q};
`else
  logic unused_ie;
  assign unused_ie = wbs_dat_i[4];
  assign ie_rd     = 1'b0;
  assign irq       = 3'b000;
`endif

  assign unused_bits = ^{wbs_dat_i[31:5], wbs_dat_i[1], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_sha3_wb_ctrl.sv
// Bench for sha3_wb_ctrl: queue-based behavioural model checked every cycle plus directed register scenarios.
`timescale 1ns/1ps
module tb_sha3_wb_ctrl;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_STAT = BASE + 32'h04;
  localparam logic [31:0] A_DATA = BASE + 32'h08;
  localparam logic [31:0] A_LAST = BASE + 32'h0C;
  localparam logic [31:0] A_DIG0 = BASE + 32'h20;
  localparam logic [31:0] A_DIG7 = BASE + 32'h3C;
  localparam logic [255:0] D1 = 256'h77777777_66666666_55555555_44444444_33333333_22222222_11111111_DEADBEA5;
  localparam logic [255:0] D2 = 256'h0_0BADF00D;
`ifdef SHA3_CTRL_IRQ_EN
  localparam logic [31:0] IRQ_DV  = 32'd1;
  localparam logic [31:0] IRQ_ERR = 32'd2;
  localparam logic [31:0] CTRL_IE = 32'h10;
`else
  localparam logic [31:0] IRQ_DV  = 32'd0;
  localparam logic [31:0] IRQ_ERR = 32'd0;
  localparam logic [31:0] CTRL_IE = 32'h0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]   wbs_sel_i = 4'h0;
  logic [31:0]  wbs_adr_i = 32'd0, wbs_dat_i = 32'd0;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic         core_in_valid, core_in_last, core_start, core_abort;
  logic         core_in_ready = 1'b0;
  logic [31:0]  core_in_data;
  logic [2:0]   core_in_bytes;
  logic         core_out_valid = 1'b0;
  logic [255:0] core_out_data = '0;
  logic [2:0]   irq;

  int n_vec = 0;
  int n_fail = 0;

  sha3_wb_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_in_data(core_in_data), .core_in_last(core_in_last), .core_in_bytes(core_in_bytes),
    .core_start(core_start), .core_abort(core_abort),
    .core_out_valid(core_out_valid), .core_out_data(core_out_data),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [35:0]  q[$];
  int           m_state = 0;   // 0 idle, 1 absorbing, 2 squeezing
  logic         m_err = 0, m_dv = 0, m_ie = 0, m_lastp = 0;
  logic         m_ack = 0, m_start = 0, m_abort = 0;
  logic [31:0]  m_rdata = 0;
  logic [255:0] m_dig = '0;

  task automatic model_step();
    logic hit, req, wr, pop, abort_w, start_w;
    int off, pre_state, pre_size;
    logic [31:0] rdat;
    logic [35:0] item;
    logic [2:0] nb;
    if (rst) begin
      q.delete(); m_state = 0; m_err = 0; m_dv = 0; m_ie = 0; m_lastp = 0;
      m_ack = 0; m_start = 0; m_abort = 0; m_rdata = 0; m_dig = '0;
      return;
    end
    hit = (wbs_adr_i[31:6] == BASE[31:6]);
    req = wbs_cyc_i && wbs_stb_i && hit && !m_ack;
    wr  = req && wbs_we_i;
    off = int'(wbs_adr_i[5:2]);
    pre_state = m_state;
    pre_size  = q.size();
    pop = (pre_state == 1) && (pre_size > 0) && core_in_ready;
    case (off)
      0: rdat = {27'd0, m_ie, 4'd0};
      1: rdat = {24'd0, (pre_size > 7) ? 3'd7 : 3'(pre_size), m_err,
                 pre_size == 0, pre_size == DEPTH, m_dv, pre_state != 0};
      default: rdat = (off >= 8) ? m_dig[(off - 8) * 32 +: 32] : 32'd0;
    endcase
    m_ack   = req;
    m_rdata = (req && !wbs_we_i) ? rdat : 32'd0;
    m_start = 0;
    m_abort = 0;
    abort_w = wr && (off == 0) && wbs_dat_i[3];
    start_w = wr && (off == 0) && wbs_dat_i[0] && !wbs_dat_i[3] && (pre_state == 0);
    if (pop) begin
      item = q.pop_front();
      if (item[35]) m_state = 2;
    end
    if (pre_state == 2 && core_out_valid && !abort_w) begin
      m_dig = core_out_data; m_dv = 1; m_state = 0;
    end
    if (wr && (off == 2 || off == 3)) begin
      if (off == 2) nb = 3'd4;
      else if (wbs_sel_i == 4'b0001) nb = 3'd1;
      else if (wbs_sel_i == 4'b0011) nb = 3'd2;
      else if (wbs_sel_i == 4'b0111) nb = 3'd3;
      else if (wbs_sel_i == 4'b1111) nb = 3'd4;
      else nb = 3'd0;
      if (pre_state == 1 && (pre_size < DEPTH || pop) && !m_lastp && nb != 0) begin
        q.push_back({(off == 3), nb, wbs_dat_i});
        m_lastp = (off == 3);
      end else begin
        m_err = 1;
      end
    end
    if (wr && off == 0) begin
      if (wbs_dat_i[2]) m_err = 0;
`ifdef SHA3_CTRL_IRQ_EN
      m_ie = wbs_dat_i[4];
`endif
    end
    if (start_w) begin m_state = 1; m_dv = 0; m_start = 1; m_lastp = 0; end
    if (abort_w) begin m_abort = (pre_state != 0); q.delete(); m_state = 0; m_lastp = 0; end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  logic        cmp_v;
  logic [35:0] cmp_hd;
  logic [2:0]  cmp_irq;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      cmp_v  = (m_state == 1) && (q.size() > 0);
      cmp_hd = cmp_v ? q[0] : 36'd0;
`ifdef SHA3_CTRL_IRQ_EN
      cmp_irq = {1'b0, m_err & m_ie, m_dv & m_ie};
`else
      cmp_irq = 3'b000;
`endif
      chk("ack", 32'(wbs_ack_o), 32'(m_ack));
      chk("rdata", wbs_dat_o, m_rdata);
      chk("in_valid", 32'(core_in_valid), 32'(cmp_v));
      chk("in_data", core_in_data, cmp_hd[31:0]);
      chk("in_last", 32'(core_in_last), 32'(cmp_hd[35]));
      chk("in_bytes", 32'(core_in_bytes), 32'(cmp_hd[34:32]));
      chk("start", 32'(core_start), 32'(m_start));
      chk("abort", 32'(core_abort), 32'(m_abort));
      chk("irq", 32'(irq), 32'(cmp_irq));
    end
  end

  // Handshake/abort observer for the hand-computed expectations.
  int          hs_n = 0;
  int          abort_n = 0;
  logic [31:0] hs_data = 0;
  logic        hs_last = 0;
  logic [2:0]  hs_bytes = 0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (core_in_valid && core_in_ready) begin
        hs_n++; hs_data = core_in_data; hs_last = core_in_last; hs_bytes = core_in_bytes;
      end
      if (core_abort) abort_n++;
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wb_drive(input logic [31:0] a, input logic we, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
  endtask

  task automatic wb_finish(output logic [31:0] rd, output logic acked);
    acked = 0; rd = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin acked = 1; rd = wbs_dat_o; break; end
    end
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd; logic ok;
    wb_drive(a, 1'b1, d, s);
    wb_finish(rd, ok);
    chk("write_ack", 32'(ok), 32'd1);
  endtask

  task automatic wb_read_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic ok;
    wb_drive(a, 1'b0, 32'd0, 4'hF);
    wb_finish(rd, ok);
    chk("read_ack", 32'(ok), 32'd1);
    chk(nm, rd, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_digest(input logic [255:0] d);
    @(posedge clk); #1;
    core_out_data = d; core_out_valid = 1;
    @(posedge clk); #1;
    core_out_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] rd; logic ok;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // reset state
    wb_read_chk("status_reset", A_STAT, 32'h08);
    wb_read_chk("ctrl_reset", A_CTRL, 32'h00);
    wb_read_chk("digest_reset", A_DIG0, 32'h0);

    // basic hash: one full word and a one-byte last word
    core_in_ready = 1; hs_n = 0;
    wb_write(A_CTRL, 32'h1, 4'hF);
    wb_write(A_DATA, 32'h6162_6364, 4'hF);
    wb_write(A_LAST, 32'h0000_0065, 4'b0001);
    cycles(3);
    chk("hs_count", 32'(hs_n), 32'd2);
    chk("hs_last_data", hs_data, 32'h65);
    chk("hs_last_flag", 32'(hs_last), 32'd1);
    chk("hs_last_bytes", 32'(hs_bytes), 32'd1);
    wb_read_chk("status_squeeze", A_STAT, 32'h09);
    pulse_digest(D1);
    wb_read_chk("digest0", A_DIG0, 32'hDEAD_BEA5);
    wb_read_chk("digest7", A_DIG7, 32'h7777_7777);
    wb_read_chk("status_done", A_STAT, 32'h0A);

    // abort with three words queued
    core_in_ready = 0;
    wb_write(A_CTRL, 32'h1, 4'hF);
    wb_write(A_DATA, 32'h1, 4'hF);
    wb_write(A_DATA, 32'h2, 4'hF);
    wb_write(A_DATA, 32'h3, 4'hF);
    wb_read_chk("status_3q", A_STAT, 32'h61);
    abort_n = 0;
    wb_write(A_CTRL, 32'h8, 4'hF);
    cycles(2);
    chk("abort_pulses", 32'(abort_n), 32'd1);
    wb_read_chk("status_abort", A_STAT, 32'h08);
    wb_read_chk("digest_kept", A_DIG0, 32'hDEAD_BEA5);

    // overflow, then push and pop on the same edge while full
    wb_write(A_CTRL, 32'h1, 4'hF);
    for (int i = 0; i < 5; i++) wb_write(A_DATA, 32'h100 + i, 4'hF);
    wb_read_chk("status_full", A_STAT, 32'h95);
    wb_write(A_CTRL, 32'h4, 4'hF);
    wb_read_chk("status_clr", A_STAT, 32'h85);
    wb_drive(A_DATA, 1'b1, 32'hAA, 4'hF);
    core_in_ready = 1;
    wb_finish(rd, ok);
    chk("full_pushpop_ack", 32'(ok), 32'd1);
    cycles(6);
    wb_read_chk("status_drained", A_STAT, 32'h09);
    wb_write(A_CTRL, 32'h8, 4'hF);

    // data write in idle, out-of-range access
    wb_write(A_DATA, 32'h12, 4'hF);
    wb_read_chk("status_idle_err", A_STAT, 32'h18);
    wb_drive(BASE + 32'h100, 1'b1, 32'h1, 4'hF);
    wb_finish(rd, ok);
    chk("out_of_range_noack", 32'(ok), 32'd0);
    wb_write(A_CTRL, 32'h4, 4'hF);
    wb_read_chk("status_idle_clr", A_STAT, 32'h08);

    // byte enables on the last word, ignored START, write after last
    core_in_ready = 0; hs_n = 0;
    wb_write(A_CTRL, 32'h1, 4'hF);
    wb_write(A_LAST, 32'h1234, 4'b0101);
    wb_read_chk("status_badsel", A_STAT, 32'h19);
    wb_write(A_LAST, 32'h4241, 4'b0011);
    wb_read_chk("status_last_q", A_STAT, 32'h31);
    wb_write(A_CTRL, 32'h1, 4'hF);
    wb_read_chk("status_start_ign", A_STAT, 32'h31);
    wb_write(A_CTRL, 32'h4, 4'hF);
    wb_read_chk("status_clr2", A_STAT, 32'h21);
    wb_write(A_DATA, 32'h99, 4'hF);
    wb_read_chk("status_after_last", A_STAT, 32'h31);
    core_in_ready = 1;
    cycles(3);
    chk("hs2_data", hs_data, 32'h4241);
    chk("hs2_bytes", 32'(hs_bytes), 32'd2);
    chk("hs2_last", 32'(hs_last), 32'd1);
    wb_read_chk("status_sq2", A_STAT, 32'h19);
    wb_write(A_CTRL, 32'h1, 4'hF);
    wb_read_chk("status_sq_start", A_STAT, 32'h19);
    pulse_digest(D2);
    wb_read_chk("status_done2", A_STAT, 32'h1A);
    wb_read_chk("digest0_b", A_DIG0, 32'h0BAD_F00D);
    wb_write(A_CTRL, 32'h4, 4'hF);
    wb_read_chk("status_done2_clr", A_STAT, 32'h0A);

    // interrupt enable
    wb_write(A_CTRL, 32'h10, 4'hF);
    wb_read_chk("ctrl_ie", A_CTRL, CTRL_IE);
    chk("irq_dv_old", 32'(irq), IRQ_DV);
    wb_write(A_CTRL, 32'h11, 4'hF);
    chk("irq_start", 32'(irq), 32'd0);
    wb_write(A_LAST, 32'h1, 4'hF);
    cycles(3);
    pulse_digest(D1);
    #1 chk("irq_done", 32'(irq), IRQ_DV);
    wb_write(A_CTRL, 32'h11, 4'hF);
    chk("irq_restart", 32'(irq), 32'd0);
    wb_write(A_CTRL, 32'h18, 4'hF);
    wb_write(A_DATA, 32'h5, 4'hF);
    chk("irq_err", 32'(irq), IRQ_ERR);
    wb_write(A_CTRL, 32'h4, 4'hF);
    chk("irq_off", 32'(irq), 32'd0);

    // asynchronous reset while squeezing
    wb_write(A_CTRL, 32'h1, 4'hF);
    wb_write(A_LAST, 32'h2, 4'hF);
    cycles(3);
    wb_read_chk("status_pre_rst", A_STAT, 32'h09);
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    chk("rst_valid", 32'(core_in_valid), 32'd0);
    chk("rst_in_data", core_in_data, 32'd0);
    chk("rst_in_last", 32'(core_in_last), 32'd0);
    chk("rst_in_bytes", 32'(core_in_bytes), 32'd0);
    chk("rst_start", 32'(core_start), 32'd0);
    chk("rst_abort", 32'(core_abort), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    wb_read_chk("status_post_rst", A_STAT, 32'h08);
    wb_read_chk("digest_post_rst", A_DIG0, 32'h0);
    wb_read_chk("ctrl_post_rst", A_CTRL, 32'h0);

    cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
